// File: rtl/mmio_bus_arbiter_pkg.sv
// mmio_pkg -- shared definitions for the MMIO bus arbiter slice.
//
// Contents:
//   MMIO_DATA_W / MMIO_ADDR_W  width of the shared data bus and address bus
//   MMIO_WAIT_DEFAULT          default number of extra hold cycles per transfer
//   mmio_state_t               arbiter sequencer states
//   pickWinner()               round-robin choice between the two requesters
package mmio_pkg;

    localparam int MMIO_DATA_W       = 32;
    localparam int MMIO_ADDR_W       = 32;
    localparam int MMIO_WAIT_DEFAULT = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } mmio_state_t;

    // Returns the index of the requester that gets the bus.  A lone request
    // always wins.  On a tie, the requester that did not win last time goes.
    // Call this only when at least one request is high.
    function automatic logic pickWinner(input logic req0,
                                        input logic req1,
                                        input logic lastGrant);
        logic grant;
        if (req0 && req1) begin
            grant = ~lastGrant;
        end else begin
            grant = req1;
        end
        return grant;
    endfunction

endpackage

// File: rtl/mmio_bus_arbiter_if.sv
// mmio_bus_arbiter_if -- requester and bus-side signals of the MMIO arbiter.
//
// Requester side (one set per requester, index 0 = core, 1 = secondary master):
//   req0/req1      transfer request, held until the matching ack
//   we0/we1        1 = write, 0 = read
//   addr0/addr1    transfer address
//   wdata0/wdata1  write data
//   ack0/ack1      one-cycle completion pulse
//   rdata          read data, valid while the matching ack is high
// Bus side:
//   addr           bus address (0 whenever no transfer is on the bus)
//   writeEn        bus write strobe
//
// The tri-state data bus is not part of this bundle; it stays a plain inout
// wire on the arbiter so the resolved net lives in one place.
//
// Modports:
//   slave   the arbiter's view (takes requests, drives acks and the bus side)
//   master  the requesters' and devices' view
interface mmio_bus_arbiter_if;
    import mmio_pkg::*;

    logic                   req0;
    logic                   req1;
    logic                   we0;
    logic                   we1;
    logic [MMIO_ADDR_W-1:0] addr0;
    logic [MMIO_ADDR_W-1:0] addr1;
    logic [MMIO_DATA_W-1:0] wdata0;
    logic [MMIO_DATA_W-1:0] wdata1;
    logic                   ack0;
    logic                   ack1;
    logic [MMIO_DATA_W-1:0] rdata;
    logic [MMIO_ADDR_W-1:0] addr;
    logic                   writeEn;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output ack0, ack1, rdata, addr, writeEn
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  ack0, ack1, rdata, addr, writeEn
    );

endinterface

// File: rtl/mmio_bus_arbiter.sv
// mmio_bus_arbiter -- two-requester round-robin arbiter and sequencer for the
// shared memory-mapped I/O bus.
//
// Each granted transfer holds address, strobe and (for writes) data on the bus
// for WAIT_CYCLES+1 cycles so negedge-sampling devices see stable values, then
// pulses the winner's ack for one cycle.  Reads capture the bus on the last
// ACCESS cycle and hold rdata until the next read completes.
//
// Parameters:
//   WAIT_CYCLES  extra cycles a transfer is held beyond the first (0..15)
//   CNT_WIDTH    width of the wait counter, must hold WAIT_CYCLES
// Ports:
//   clk     single clock, all state changes on the rising edge
//   resetN  synchronous active-low reset
//   mif     requester and bus-side signals (slave modport)
//   bus     tri-state data bus, driven only during a write ACCESS
module mmio_bus_arbiter
    import mmio_pkg::*;
#(
    parameter int WAIT_CYCLES = MMIO_WAIT_DEFAULT,
    parameter int CNT_WIDTH   = 4
) (
    input  logic                   clk,
    input  logic                   resetN,
    mmio_bus_arbiter_if.slave      mif,
    inout  wire  [MMIO_DATA_W-1:0] bus
);

    mmio_state_t            state;
    mmio_state_t            nextState;
    logic [CNT_WIDTH-1:0]   cnt;
    logic                   winner;
    logic                   lastGrant;
    logic                   latchWe;
    logic [MMIO_ADDR_W-1:0] latchAddr;
    logic [MMIO_DATA_W-1:0] latchWdata;
    logic                   busDrive;
    logic                   anyReq;
    logic                   grantNext;
    logic                   pickWe;
    logic [MMIO_ADDR_W-1:0] pickAddr;
    logic [MMIO_DATA_W-1:0] pickWdata;

    // Arbitration: decide who would win if IDLE samples this cycle, and steer
    // that requester's command towards the transfer latch.
    always_comb begin
        anyReq    = mif.req0 || mif.req1;
        grantNext = pickWinner(mif.req0, mif.req1, lastGrant);
        pickWe    = grantNext ? mif.we1    : mif.we0;
        pickAddr  = grantNext ? mif.addr1  : mif.addr0;
        pickWdata = grantNext ? mif.wdata1 : mif.wdata0;
    end

    // State register.  Reset lands in IDLE on the same edge, which drops the
    // strobe, address and bus drive immediately because those are decoded
    // from the state.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state and output decode.  Outputs depend only on the registered
    // state and latch, so the bus side changes just after a rising edge and
    // is stable by the following falling edge where devices sample.
    always_comb begin
        nextState   = state;
        mif.addr    = '0;
        mif.writeEn = 1'b0;
        mif.ack0    = 1'b0;
        mif.ack1    = 1'b0;
        busDrive    = 1'b0;
        case (state)
            IDLE: begin
                if (anyReq) begin
                    nextState = ACCESS;
                end
            end
            ACCESS: begin
                mif.addr    = latchAddr;
                mif.writeEn = latchWe;
                busDrive    = latchWe;
                if (cnt == '0) begin
                    nextState = ACK;
                end
            end
            ACK: begin
                mif.ack0  = ~winner;
                mif.ack1  = winner;
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Transfer latch, wait counter, read capture and round-robin history.
    // The command is latched when IDLE accepts a request, so requesters may
    // change their inputs freely after the ack without disturbing the bus.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            cnt        <= '0;
            winner     <= 1'b0;
            lastGrant  <= 1'b1;
            latchWe    <= 1'b0;
            latchAddr  <= '0;
            latchWdata <= '0;
            mif.rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (anyReq) begin
                        winner     <= grantNext;
                        latchWe    <= pickWe;
                        latchAddr  <= pickAddr;
                        latchWdata <= pickWdata;
                        cnt        <= CNT_WIDTH'(WAIT_CYCLES);
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        if (!latchWe) begin
                            mif.rdata <= bus;
                        end
                    end else begin
                        cnt <= cnt - CNT_WIDTH'(1);
                    end
                end
                ACK: begin
                    lastGrant <= winner;
                end
                default: begin
                end
            endcase
        end
    end

    // Tri-state driver: write data only while a write is on the bus.
    assign bus = busDrive ? latchWdata : {MMIO_DATA_W{1'bz}};

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// tb_mmio_bus_arbiter -- self-checking bench for mmio_bus_arbiter.
//
// Main instance (WAIT_CYCLES=1) talks to a two-register negedge device at
// 0xF0000000/0xF0000004 and to a bus probe that drives zero to show the
// arbiter has released the bus.  Two extra instances (WAIT_CYCLES=0 and 15)
// are used for the wait-length sweep.
module tb_mmio_bus_arbiter;

    localparam int W = 1;

    typedef struct {
        logic        req0;
        logic        req1;
        logic        we0;
        logic        we1;
        logic [31:0] addr0;
        logic [31:0] addr1;
        logic [31:0] wdata0;
        logic [31:0] wdata1;
        logic        expAck1;
        logic [31:0] expRdata;
    } vec_t;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    logic probeEn = 1'b0;
    wire [31:0] bus;
    wire [31:0] bus0;
    wire [31:0] bus15;

    int assertCount = 0;
    int failCount = 0;

    always #5 clk = ~clk;

    mmio_bus_arbiter_if mif();
    mmio_bus_arbiter_if sif0();
    mmio_bus_arbiter_if sif15();

    mmio_bus_arbiter #(.WAIT_CYCLES(W), .CNT_WIDTH(4)) dut (
        .clk(clk), .resetN(resetN), .mif(mif), .bus(bus)
    );
    mmio_bus_arbiter #(.WAIT_CYCLES(0), .CNT_WIDTH(4)) dutW0 (
        .clk(clk), .resetN(resetN), .mif(sif0), .bus(bus0)
    );
    mmio_bus_arbiter #(.WAIT_CYCLES(15), .CNT_WIDTH(4)) dutW15 (
        .clk(clk), .resetN(resetN), .mif(sif15), .bus(bus15)
    );

    // Simple I/O device: two registers, written on the falling edge while the
    // strobe is high, and driving the bus during a read of its address.
    logic [31:0] devReg [2];
    logic        devHit;
    assign devHit = (mif.addr & 32'hFFFF_FFF8) == 32'hF000_0000;

    always @(negedge clk) begin
        if (mif.writeEn && devHit) begin
            devReg[mif.addr[2]] <= bus;
        end
    end

    assign bus = (devHit && !mif.writeEn) ? devReg[mif.addr[2]] : 32'bz;
    assign bus = probeEn ? 32'h0 : 32'bz;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        mif.req0   = v.req0;
        mif.req1   = v.req1;
        mif.we0    = v.we0;
        mif.we1    = v.we1;
        mif.addr0  = v.addr0;
        mif.addr1  = v.addr1;
        mif.wdata0 = v.wdata0;
        mif.wdata1 = v.wdata1;
    endtask

    // Drives zero onto the bus for a moment; the net reads back zero only if
    // nothing else is driving it.
    task automatic checkBusReleased(input string name);
        probeEn = 1'b1;
        #1;
        checkOutput(name, bus, 32'h0);
        probeEn = 1'b0;
    endtask

    // Applies one record from IDLE, checks every ACCESS cycle, the ack cycle
    // and that the ack is gone one cycle later.
    task automatic runTransfer(input vec_t v, input string tag, input bit releaseAfter);
        logic [31:0] expAddr;
        logic [31:0] expData;
        logic        expWe;
        int          n;
        bit          seen;
        expAddr = v.expAck1 ? v.addr1 : v.addr0;
        expWe   = v.expAck1 ? v.we1 : v.we0;
        expData = expWe ? (v.expAck1 ? v.wdata1 : v.wdata0) : v.expRdata;
        applyStimulus(v);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (mif.ack0 || mif.ack1) begin
                seen = 1'b1;
            end else begin
                checkOutput({tag, " access addr"}, mif.addr, expAddr);
                checkOutput({tag, " access writeEn"}, 32'(mif.writeEn), 32'(expWe));
                checkOutput({tag, " access bus"}, bus, expData);
            end
        end
        checkOutput({tag, " ack latency"}, 32'(n), 32'(W + 2));
        checkOutput({tag, " ack0"}, 32'(mif.ack0), 32'(!v.expAck1));
        checkOutput({tag, " ack1"}, 32'(mif.ack1), 32'(v.expAck1));
        checkOutput({tag, " rdata"}, mif.rdata, v.expRdata);
        checkOutput({tag, " ack writeEn"}, 32'(mif.writeEn), 32'h0);
        checkOutput({tag, " ack addr"}, mif.addr, 32'h0);
        checkBusReleased({tag, " ack bus released"});
        if (releaseAfter) begin
            mif.req0 = 1'b0;
            mif.req1 = 1'b0;
        end
        @(posedge clk);
        #1;
        checkOutput({tag, " ack0 single pulse"}, 32'(mif.ack0), 32'h0);
        checkOutput({tag, " ack1 single pulse"}, 32'(mif.ack1), 32'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[9];
        vec_t tieV;
        vec_t abortV;
        vec_t postV;
        int   acc0;
        int   acc15;
        int   lat0;
        int   lat15;

        vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'hF000_0000, 32'h0,          32'h0000_00A5, 32'h0,          1'b0, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,          32'hF000_0004, 32'h0,          32'h0,          1'b1, 32'h0000_003C};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'hF000_0000, 32'h0,          32'h0,          32'h0,          1'b0, 32'h0000_00A5};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0,          32'hF000_0004, 32'h0,          32'h1234_5678, 1'b1, 32'h0000_00A5};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,          32'hF000_0004, 32'h0,          32'h0,          1'b1, 32'h1234_5678};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'hF000_0000, 32'hF000_0004, 32'h5A5A_0001, 32'h0,          1'b0, 32'h1234_5678};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'hF000_0000, 32'hF000_0004, 32'h5A5A_0001, 32'h0,          1'b1, 32'h1234_5678};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'hF000_0000, 32'hF000_0004, 32'h5A5A_0001, 32'h0,          1'b0, 32'h1234_5678};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'hF000_0000, 32'h0,          32'h0,          32'h0,          1'b0, 32'h5A5A_0001};

        tieV   = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hF000_0000, 32'hF000_0004, 32'h0000_0011, 32'h0000_003C, 1'b0, 32'h0};
        abortV = '{1'b1, 1'b0, 1'b1, 1'b0, 32'hF000_0000, 32'h0,          32'hCAFE_0000, 32'h0,          1'b0, 32'h0};
        postV  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'hF000_0000, 32'hF000_0004, 32'h0,          32'h0000_0099, 1'b0, 32'hCAFE_0000};

        applyStimulus('{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0});
        sif0.req0 = 1'b0;  sif0.req1 = 1'b0;  sif0.we0 = 1'b0;  sif0.we1 = 1'b0;
        sif0.addr0 = '0;   sif0.addr1 = '0;   sif0.wdata0 = '0; sif0.wdata1 = '0;
        sif15.req0 = 1'b0; sif15.req1 = 1'b0; sif15.we0 = 1'b0; sif15.we1 = 1'b0;
        sif15.addr0 = '0;  sif15.addr1 = '0;  sif15.wdata0 = '0; sif15.wdata1 = '0;

        // Reset state.
        resetN = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset ack0", 32'(mif.ack0), 32'h0);
        checkOutput("reset ack1", 32'(mif.ack1), 32'h0);
        checkOutput("reset addr", mif.addr, 32'h0);
        checkOutput("reset writeEn", 32'(mif.writeEn), 32'h0);
        checkOutput("reset rdata", mif.rdata, 32'h0);
        checkBusReleased("reset bus released");
        resetN = 1'b1;

        // Both requests held out of reset: grants alternate 0, 1, 0, 1.
        for (int i = 0; i < 4; i++) begin
            tieV.expAck1 = (i % 2) == 1;
            runTransfer(tieV, $sformatf("tie%0d", i), i == 3);
        end

        // Directed vector table.
        for (int i = 0; i < 9; i++) begin
            runTransfer(vecs[i], $sformatf("vec%0d", i), 1'b1);
        end
        checkOutput("device reg0", devReg[0], 32'h5A5A_0001);
        checkOutput("device reg1", devReg[1], 32'h1234_5678);

        // Reset in the second ACCESS cycle of a write.
        applyStimulus(abortV);
        @(posedge clk);
        #1;
        checkOutput("abort access1 writeEn", 32'(mif.writeEn), 32'h1);
        @(posedge clk);
        #1;
        checkOutput("abort access2 addr", mif.addr, 32'hF000_0000);
        resetN = 1'b0;
        mif.req0 = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort ack0", 32'(mif.ack0), 32'h0);
        checkOutput("abort ack1", 32'(mif.ack1), 32'h0);
        checkOutput("abort writeEn", 32'(mif.writeEn), 32'h0);
        checkOutput("abort addr", mif.addr, 32'h0);
        checkOutput("abort rdata", mif.rdata, 32'h0);
        checkBusReleased("abort bus released");
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("abort no ack %0d", i), 32'(mif.ack0 | mif.ack1), 32'h0);
        end
        resetN = 1'b1;
        runTransfer(postV, "post-reset tie", 1'b1);

        // Wait sweep on the W=0 and W=15 instances, run side by side.
        sif0.req0 = 1'b1;  sif0.we0 = 1'b1;  sif0.addr0 = 32'h100;  sif0.wdata0 = 32'h77;
        sif15.req0 = 1'b1; sif15.we0 = 1'b1; sif15.addr0 = 32'h100; sif15.wdata0 = 32'h77;
        acc0 = 0; acc15 = 0; lat0 = 0; lat15 = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk);
            #1;
            if (sif0.writeEn) acc0++;
            if (sif15.writeEn) acc15++;
            if (sif0.ack0 && lat0 == 0) begin
                lat0 = cyc;
                sif0.req0 = 1'b0;
            end
            if (sif15.ack0 && lat15 == 0) begin
                lat15 = cyc;
                sif15.req0 = 1'b0;
            end
        end
        checkOutput("W0 access length", 32'(acc0), 32'd1);
        checkOutput("W0 ack latency", 32'(lat0), 32'd2);
        checkOutput("W15 access length", 32'(acc15), 32'd16);
        checkOutput("W15 ack latency", 32'(lat15), 32'd17);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
